// File: rtl/int_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// int_scheduler_pkg
// Shared definitions for the interrupt scheduler and the CP0 vector logic.
//   sched_state_t  : scheduler FSM encoding (IDLE, REQ, HOLD)
//   DEF_VEC_BASE   : default handler address of source 0
//   DEF_VEC_STRIDE : default spacing between consecutive source vectors
//   vec_addr()     : base + idx*stride, wrapping modulo 2^32
// ---------------------------------------------------------------------------
package int_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0800;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

    // Handler address for a source index; the 32-bit result wraps naturally.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] idx);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// ---------------------------------------------------------------------------
// int_prio_enc
// Highest-set-bit encoder. Bit W-1 has the highest priority.
//   req   in  W   request vector
//   valid out 1   at least one request bit is set
//   idx   out IW  index of the highest set bit (0 when valid = 0)
// ---------------------------------------------------------------------------
module int_prio_enc #(
    parameter int W  = 3,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scanning upward lets the last (highest) set bit win.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < W; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/int_scheduler.sv
// ---------------------------------------------------------------------------
// int_scheduler
// Nested, vectored interrupt scheduler between the raw sources and CP0.
// Edge-detects sources, tracks pending / in-service levels, requests the
// highest eligible source from the CPU and supplies its handler vector.
//   clk        in  1     system clock
//   rst        in  1     synchronous, active-low reset
//   intsrc     in  NSRC  raw interrupt lines (rising edge = event)
//   ie         in  1     global interrupt enable
//   mask       in  NSRC  per-source enable (1 = allowed)
//   irq        out 1     interrupt request to the CPU
//   irq_ack    in  1     CPU has taken the request (pulse)
//   eret       in  1     handler has returned (pulse)
//   vector     out 32    handler address of the current winner
//   pending    out NSRC  latched, not-yet-serviced events
//   in_service out NSRC  sources being serviced, including nested ones
// ---------------------------------------------------------------------------
module int_scheduler
    import int_scheduler_pkg::*;
#(
    parameter int          NSRC       = 3,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] intsrc,
    input  logic            ie,
    input  logic [NSRC-1:0] mask,
    output logic            irq,
    input  logic            irq_ack,
    input  logic            eret,
    output logic [31:0]     vector,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] in_service
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    sched_state_t    state, state_nx;
    logic [IW-1:0]   win, win_nx;
    logic [NSRC-1:0] prev;
    logic [NSRC-1:0] ev;
    logic [NSRC-1:0] above;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] ack_set;
    logic [NSRC-1:0] eret_clr;
    logic            take_ack;
    logic            top_valid;
    logic [IW-1:0]   top_idx;
    logic            cand_valid;
    logic [IW-1:0]   cand_idx;

    // Current nesting level: highest in-service source.
    int_prio_enc #(.W(NSRC), .IW(IW)) u_top_enc (
        .req   (in_service),
        .valid (top_valid),
        .idx   (top_idx)
    );

    // Best eligible candidate: highest pending, unmasked source above the
    // current nesting level.
    int_prio_enc #(.W(NSRC), .IW(IW)) u_win_enc (
        .req   (cand),
        .valid (cand_valid),
        .idx   (cand_idx)
    );

    // Event detection, eligibility window and the eret retire mask. eret
    // always retires the innermost level, using in_service before any
    // same-cycle acknowledge lands.
    always_comb begin
        ev       = intsrc & ~prev;
        above    = '0;
        eret_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            above[i] = !top_valid || (IW'(i) > top_idx);
        end
        cand = pending & mask & above;
        if (eret && top_valid) begin
            eret_clr[top_idx] = 1'b1;
        end
    end

    // Next-state logic. win is only loaded on the IDLE->REQ step so a later,
    // higher-priority arrival cannot change a request already presented.
    // An acknowledge takes precedence over a same-cycle withdrawal.
    always_comb begin
        state_nx = state;
        win_nx   = win;
        take_ack = 1'b0;
        ack_set  = '0;
        case (state)
            IDLE: begin
                if (ie && cand_valid) begin
                    win_nx   = cand_idx;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    take_ack = 1'b1;
                    state_nx = HOLD;
                end else if (!ie || !mask[win]) begin
                    state_nx = IDLE;
                end
            end
            HOLD: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (take_ack) begin
            ack_set[win] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered datapath and outputs. A new event is OR-ed in after the
    // acknowledge clear, so an event arriving with the ack is not lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev       <= '0;
            win        <= '0;
            irq        <= 1'b0;
            vector     <= VEC_BASE;
            pending    <= '0;
            in_service <= '0;
        end else begin
            prev       <= intsrc;
            win        <= win_nx;
            irq        <= (state_nx == REQ);
            vector     <= vec_addr(VEC_BASE, VEC_STRIDE, 32'(win_nx));
            pending    <= (pending & ~ack_set) | ev;
            in_service <= (in_service & ~eret_clr) | ack_set;
        end
    end

endmodule

// File: doc/int_scheduler.md
# int_scheduler

Nested, vectored interrupt scheduler that sits between the raw interrupt sources and the CPU's CP0 interrupt entry. It edge-detects the sources, holds pending and in-service state, and picks the highest-priority eligible source. It raises a request/acknowledge handshake toward the pipeline and supplies the handler vector. ERET retires in-service levels in nesting order.

## Interface
Parameters:
- NSRC, 3, number of interrupt sources; index NSRC-1 has the highest priority.
- VEC_BASE, 32'h0000_0800, vector address for source 0.
- VEC_STRIDE, 32'h0000_0010, address spacing between consecutive source vectors.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- intsrc  in  NSRC  raw interrupt lines; a rising edge is an event.
- ie  in  1  global interrupt enable (Status IE).
- mask  in  NSRC  per-source enable; 1 = allowed.
- irq  out  1  interrupt request to the CPU.
- irq_ack  in  1  one-cycle pulse: the CPU has taken the request.
- eret  in  1  one-cycle pulse: the handler has returned.
- vector  out  32  handler address for the current winner; valid while irq = 1.
- pending  out  NSRC  latched, not-yet-serviced events (readable as Cause IP).
- in_service  out  NSRC  sources currently being serviced, including nested ones.

## Operation
- Edge detect: the block registers intsrc into prev every cycle. An event on source i is intsrc[i] & ~prev[i]. The event sets pending[i].
- Top level: the highest set bit of in_service; -1 if in_service = 0.
- Candidate: (pending & mask). Eligible means priority strictly above the top level. The winner is the highest eligible index.
- FSM states:
  - IDLE: irq = 0. If ie = 1 and an eligible source exists, latch the winner into win and go to REQ.
  - REQ: irq = 1, vector = VEC_BASE + win*VEC_STRIDE, computed modulo 2^32.
    - win stays frozen in REQ. A higher-priority arrival waits for the next pass.
    - On irq_ack: set in_service[win], clear pending[win], go to HOLD.
    - Else if ie = 0 or mask[win] = 0: withdraw the request (irq = 0) and go to IDLE. pending is left unchanged.
  - HOLD: irq = 0 for one cycle so the CP0 clearing of IE can propagate. Then go to IDLE.
- eret: clears the highest set bit of the pre-update in_service. eret has no effect when in_service = 0. It is legal in any state.
- Simultaneous events:
  - An event and an irq_ack on the same source in one cycle: pending stays 1, so the new event is kept.
  - eret and irq_ack in one cycle: the eret clear uses the old in_service value, then in_service[win] is set.
  - irq_ack outside REQ is ignored.
- Reset (rst = 0 at a clock edge, any state): state = IDLE, irq = 0, vector = VEC_BASE, pending = 0, in_service = 0, win = 0, prev = 0. A source held high through reset release therefore produces one event.

## Timing
- An edge sampled at edge t gives pending = 1 after t, irq = 1 after t+1. Event-to-request latency is 2 cycles.
- irq_ack at edge a: irq = 0 and in_service updated after a. The earliest re-request is after a+2 (HOLD, then IDLE evaluation).
- The request is withdrawn one cycle after ie or mask drops.
- eret takes effect on the edge that samples it. A newly eligible lower source can assert irq 2 cycles later (IDLE evaluation, then REQ).
- All outputs are registered. vector is a registered function of win.

## Structure
- Shared package holds the FSM state encoding (IDLE, REQ, HOLD) and default VEC_BASE/VEC_STRIDE constants. CP0 reuses them for vector generation.
- One natural sub-module: int_prio_enc, a parameterised highest-set-bit encoder with a valid flag. It is instantiated twice: once for the winner and once for the top level.

## Test plan
- Single source: with ie = 1 and mask = 3'b111, pulse intsrc[0]. irq rises 2 cycles later with vector = 32'h800. After the ack: in_service = 3'b001 and pending = 0. After eret: in_service = 0.
- Priority: raise sources 0 and 2 in the same cycle. The first request has vector = 32'h820. After ack and eret, the second request has vector = 32'h800.
- Nesting: source 0 in service, then pulse source 1. A request with vector 32'h810 is issued; after its ack, in_service = 3'b011. The first eret gives 3'b001, the second gives 3'b000.
- Blocking: source 2 in service, then pulse source 1. irq stays 0 and pending = 3'b010. After eret, irq rises 2 cycles later with vector 32'h810.
- Withdrawal: drop ie during REQ. irq = 0 the next cycle and pending is unchanged. Re-raise ie: the same vector is requested again.
- Reset mid-request: assert rst low while in REQ. After the edge: irq = 0, pending = 0, in_service = 0, vector = 32'h800. Hold intsrc[1] high across reset release: exactly one request with vector 32'h810.
